// File: rtl/dino_pkg.sv
// dino_pkg: shared game state encoding and widths for the dino runner
package dino_pkg;
  localparam int X_WIDTH = 10;
  localparam int SCORE_WIDTH = 16;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    q <= reset ? SEED : {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: game FSM, two-slot cactus spawn/scroll, speed ramp and score
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int X_WIDTH = dino_pkg::X_WIDTH,
  parameter int SPAWN_X = 600,
  parameter int MIN_GAP = 200,
  parameter int MIN_GAP_FRAMES = 40,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX = 6,
  parameter int SPEED_STEP_FRAMES = 512,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   collision,
  output logic [1:0]             state,
  output logic                   game_over,
  output logic [1:0]             cacti_valid,
  output logic [X_WIDTH-1:0]     cacti_x0,
  output logic [X_WIDTH-1:0]     cacti_x1,
  output logic [2:0]             speed,
  output logic [SCORE_WIDTH-1:0] score
);
  localparam int GW = $clog2(MIN_GAP_FRAMES + 32);
  localparam int FW = SPEED_STEP_FRAMES > 1 ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam logic [X_WIDTH-1:0] LIM = X_WIDTH'(SPAWN_X - MIN_GAP);
  logic [15:0] lfsr;
  logic [GW-1:0] gap;
  logic [FW-1:0] frame;
  logic [1:0] nv;
  logic [X_WIDTH-1:0] nx0, nx1, sp;
  logic sp0, sp1, wrap;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
  // nv/nx: slot liveness and position after this tick's scroll, before any spawn
  always_comb begin
    sp = X_WIDTH'(speed);
    nv = {cacti_valid[1] && cacti_x1 >= sp, cacti_valid[0] && cacti_x0 >= sp};
    nx0 = cacti_x0 - sp;
    nx1 = cacti_x1 - sp;
    sp0 = gap == '0 && !cacti_valid[0] && (!nv[1] || nx1 <= LIM);
    sp1 = gap == '0 && !sp0 && !cacti_valid[1] && (!nv[0] || nx0 <= LIM);
    wrap = frame == FW'(SPEED_STEP_FRAMES - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      game_over <= 1'b0;
      cacti_valid <= 2'b00;
      cacti_x0 <= X_WIDTH'(SPAWN_X);
      cacti_x1 <= X_WIDTH'(SPAWN_X);
      speed <= 3'(SPEED_INIT);
      score <= '0;
      frame <= '0;
      gap <= GW'(MIN_GAP_FRAMES);
    end else if (state == ST_RUN && collision) begin
      state <= ST_OVER;
      game_over <= 1'b1;
    end else if (state != ST_RUN && start) begin
      state <= ST_RUN;
      game_over <= 1'b0;
      cacti_valid <= 2'b00;
      speed <= 3'(SPEED_INIT);
      score <= '0;
      frame <= '0;
      gap <= '0;
    end else if (state == ST_RUN && frame_tick) begin
      cacti_valid <= nv | {sp1, sp0};
      cacti_x0 <= sp0 ? X_WIDTH'(SPAWN_X) : nv[0] ? nx0 : cacti_x0;
      cacti_x1 <= sp1 ? X_WIDTH'(SPAWN_X) : nv[1] ? nx1 : cacti_x1;
      gap <= (sp0 || sp1) ? GW'(MIN_GAP_FRAMES) + GW'(lfsr[4:0]) : gap - GW'(gap != '0);
      score <= score + SCORE_WIDTH'(score != '1);
      frame <= wrap ? '0 : frame + 1'b1;
      if (wrap && speed < 3'(SPEED_MAX)) speed <= speed + 3'd1;
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: random stimulus against a behavioural game model
module tb_obstacle_scheduler;
  localparam int SPAWN = 600, GAP = 200, MGF = 40, SINIT = 1, SMAX = 4, STEP = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, reset = 1, frame_tick = 0, start = 0, collision = 0;
  logic [1:0] state, cacti_valid;
  logic game_over;
  logic [9:0] cacti_x0, cacti_x1;
  logic [2:0] speed;
  logic [15:0] score;
  int tests = 0, fails = 0;
  int m_st, msp, msc, mfc, mgap;
  int mx[2];
  bit mv[2];
  logic [15:0] ml;
  obstacle_scheduler #(.SPEED_MAX(SMAX), .SPEED_STEP_FRAMES(STEP)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .collision(collision),
    .state(state), .game_over(game_over), .cacti_valid(cacti_valid),
    .cacti_x0(cacti_x0), .cacti_x1(cacti_x1), .speed(speed), .score(score));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(bit r, bit s, bit c, bit t);
    logic [15:0] l;
    bit was_free[2];
    int slot;
    l = ml;
    ml = r ? SEED : {ml[14:0], ^(ml & 16'hB400)};
    if (r) begin
      m_st = 0; mv = '{0, 0}; mx = '{SPAWN, SPAWN}; msp = SINIT; msc = 0; mfc = 0; mgap = MGF;
    end else if (m_st == 1 && c) m_st = 2;
    else if (m_st != 1 && s) begin
      m_st = 1; mv = '{0, 0}; msc = 0; msp = SINIT; mfc = 0; mgap = 0;
    end else if (m_st == 1 && t) begin
      slot = -1;
      for (int i = 0; i < 2; i++) begin
        was_free[i] = !mv[i];
        if (mv[i]) begin
          if (mx[i] < msp) mv[i] = 0;
          else mx[i] -= msp;
        end
      end
      if (mgap == 0)
        for (int i = 0; i < 2; i++)
          if (slot < 0 && was_free[i] && (!mv[1-i] || mx[1-i] <= SPAWN - GAP)) slot = i;
      if (slot >= 0) begin
        mv[slot] = 1; mx[slot] = SPAWN; mgap = MGF + int'(l[4:0]);
      end else if (mgap > 0) mgap--;
      if (msc < 65535) msc++;
      mfc++;
      if (mfc == STEP) begin
        mfc = 0;
        if (msp < SMAX) msp++;
      end
    end
  endtask
  task automatic cyc(bit r, bit s, bit c, bit t);
    @(negedge clk);
    reset = r; start = s; collision = c; frame_tick = t;
    @(posedge clk);
    model(r, s, c, t);
    #1;
    check("state", state, m_st);
    check("game_over", game_over, m_st == 2);
    check("valid", cacti_valid, {mv[1], mv[0]});
    check("x0", cacti_x0, mx[0]);
    check("x1", cacti_x1, mx[1]);
    check("speed", speed, msp);
    check("score", score, msc);
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 400; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 40000; i++)
      cyc($urandom_range(2999) == 0, $urandom_range(49) == 0,
          $urandom_range(399) == 0, $urandom_range(1) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Game-sequencing controller for the dino runner display path. It owns the game state machine (IDLE/RUN/OVER), schedules up to two cactus obstacles (spawn, per-frame scroll, despawn), ramps scroll speed and keeps the score. The VGA renderer reads its registered outputs as sprite positions, and feeds back the frame-end pulse and the pixel-collision flag.

Parameters:
X_WIDTH, 10, width of obstacle x coordinates
SPAWN_X, 600, x loaded into a slot on spawn
MIN_GAP, 200, minimum pixel distance from SPAWN_X to the other live obstacle before a spawn is allowed
MIN_GAP_FRAMES, 40, base frame delay between spawns
SPEED_INIT, 1, pixels per frame at start of a run
SPEED_MAX, 6, saturation value of speed
SPEED_STEP_FRAMES, 512, frame ticks per speed increment
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
frame_tick  in  1  single-cycle pulse per frame end, synchronous to clk
start  in  1  level; sampled each cycle, starts or restarts a run
collision  in  1  sprite-overlap flag from renderer
state  out  2  00 IDLE, 01 RUN, 10 OVER
game_over  out  1  high iff state==OVER
cacti_valid  out  2  bit i = slot i live
cacti_x0  out  X_WIDTH  slot 0 x
cacti_x1  out  X_WIDTH  slot 1 x
speed  out  3  current pixels/frame
score  out  16  frames survived in current run

Behaviour:
- All outputs registered; effects of an input visible the cycle after it is sampled.
- Reset values: state=IDLE, game_over=0, cacti_valid=00, cacti_x0=cacti_x1=SPAWN_X, speed=SPEED_INIT, score=0, frame counter=0, gap counter=MIN_GAP_FRAMES, LFSR=LFSR_SEED. Reset mid-run has the same effect.
- FSM: IDLE --start--> RUN; RUN --collision--> OVER; OVER --start--> RUN. No other transitions. collision ignored outside RUN.
- Entering RUN (from IDLE or OVER): valid=00, score=0, speed=SPEED_INIT, frame counter=0, gap counter=0 (spawn allowed on first tick).
- frame_tick outside RUN: ignored, all positions/score frozen.
- On frame_tick in RUN, in order:
  1. Move: each live slot x <= x - speed; if x < speed the slot becomes invalid instead (no underflow).
  2. Spawn: if gap counter==0 and a slot was invalid before this tick and the other slot is invalid or its new x <= SPAWN_X-MIN_GAP, spawn into the lowest-index free slot at SPAWN_X; gap counter <= MIN_GAP_FRAMES + LFSR[4:0]. A slot freed on this tick is not reused until the next tick. A spawned obstacle is not moved on its spawn tick. At most one spawn per tick.
  3. Else if gap counter != 0, decrement it.
  4. score <= score+1, saturating at 16'hFFFF.
  5. frame counter increments; at SPEED_STEP_FRAMES-1 it wraps to 0 and speed <= min(speed+1, SPEED_MAX).
- collision and frame_tick in the same RUN cycle: collision wins; move to OVER, no move/spawn/score/speed update.
- start and collision in the same RUN cycle: collision wins.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, steps every clk cycle in all states, so spawn timing depends on player start time.

Decomposition:
- Shared package dino_pkg: state encoding (ST_IDLE, ST_RUN, ST_OVER), X_WIDTH, SCORE_WIDTH=16. The renderer imports the same package.
- One sub-module: lfsr16 (clk, reset, seed parameter, 16-bit state output).

Test Plan:
1. Reset, then 5 frame_ticks with start=0 -> state=00, cacti_valid=00, score=0, speed=1, game_over=0 throughout.
2. Pulse start, then one frame_tick -> cacti_valid=01, cacti_x0=600, score=1. Next tick -> cacti_x0=599, score=2.
3. SPEED_STEP_FRAMES=4, SPEED_MAX=3, run 12 ticks -> speed=2 after tick 4, 3 after tick 8, still 3 after tick 12.
4. Slot0 x=1 with speed=2, then tick -> cacti_valid[0]=0, no underflow value on cacti_x0. Slot0 x=500 with gap counter 0 -> slot1 not spawned until x0 <= 400, then cacti_x1=600.
5. RUN with x0=300, score=50; collision and frame_tick in the same cycle -> state=OVER, game_over=1, x0 stays 300, score stays 50. Further ticks and collisions change nothing.
6. From OVER, assert start -> next cycle state=RUN, game_over=0, cacti_valid=00, score=0, speed=1. Assert reset mid-run -> all reset values.
